// File: rtl/video_timing_gen.sv
// Free-running raster timing: horizontal/vertical counters plus registered
// sync, burst, active-video and line/frame start flags.
module video_timing_gen #(
    parameter int H_TOTAL      = 1728,
    parameter int HSYNC_LEN    = 127,
    parameter int BURST_START  = 151,
    parameter int BURST_LEN    = 60,
    parameter int ACTIVE_START = 284,
    parameter int ACTIVE_LEN   = 1404,
    parameter int V_TOTAL      = 312,
    parameter int VSYNC_LINES  = 3,
    parameter int V_ACT_START  = 23,
    parameter int V_ACT_LEN    = 288,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          sync,
    output logic          burst,
    output logic          active,
    output logic          line_start,
    output logic          frame_start
);

    typedef enum logic [2:0] {
        H_SYNC,
        H_PORCH1,
        H_BURST,
        H_PORCH2,
        H_ACTIVE,
        H_FRONT
    } h_state_e;

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(HSYNC_LEN);
    localparam logic [HW-1:0] H_BURST_BEG = HW'(BURST_START);
    localparam logic [HW-1:0] H_BURST_END = HW'(BURST_START + BURST_LEN);
    localparam logic [HW-1:0] H_ACT_BEG   = HW'(ACTIVE_START);
    localparam logic [HW-1:0] H_ACT_END   = HW'(ACTIVE_START + ACTIVE_LEN);
    localparam logic [HW-1:0] H_BROAD_END = HW'(H_TOTAL - HSYNC_LEN);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_ACT_BEG   = VW'(V_ACT_START);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACT_START + V_ACT_LEN);

    if (HSYNC_LEN >= BURST_START ||
        BURST_START + BURST_LEN > ACTIVE_START ||
        ACTIVE_START + ACTIVE_LEN > H_TOTAL ||
        V_ACT_START + V_ACT_LEN > V_TOTAL ||
        VSYNC_LINES >= V_ACT_START) begin : g_param_error
        $error("video_timing_gen: inconsistent timing parameters");
    end

    h_state_e      state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          sync_q, sync_d;
    logic          burst_q, burst_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Flags are derived from the *next* counter values so they register in
    // step with the counters and never form a combinational output path.
    logic vsync_line_d;
    logic v_active_d;
    assign vsync_line_d = (v_cnt_d < V_SYNC_END);
    assign v_active_d   = (v_cnt_d >= V_ACT_BEG) && (v_cnt_d < V_ACT_END);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this
        // block leaves a variable unassigned (which would infer a latch).
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        state_d       = state_q;
        sync_d        = sync_q;
        burst_d       = burst_q;
        active_d      = active_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        if (ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end

            // Burst end may coincide with active start, so H_ACTIVE wins.
            if (h_cnt_d == '0)              state_d = H_SYNC;
            else if (h_cnt_d == H_ACT_END)  state_d = H_FRONT;
            else if (h_cnt_d == H_ACT_BEG)  state_d = H_ACTIVE;
            else if (h_cnt_d == H_BURST_END) state_d = H_PORCH2;
            else if (h_cnt_d == H_BURST_BEG) state_d = H_BURST;
            else if (h_cnt_d == H_SYNC_END) state_d = H_PORCH1;

            sync_d        = vsync_line_d ? (h_cnt_d < H_BROAD_END) : (state_d == H_SYNC);
            burst_d       = !vsync_line_d && (state_d == H_BURST);
            active_d      = v_active_d && (state_d == H_ACTIVE);
            line_start_d  = (h_cnt_d == '0);
            frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= H_SYNC;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            sync_q        <= 1'b1;
            burst_q       <= 1'b0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            sync_q        <= sync_d;
            burst_q       <= burst_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign sync        = sync_q;
    assign burst       = burst_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full-size raster plus a shrunken raster, both
// checked every cycle against a position-from-ce-count reference model.
module tb_video_timing_gen;

    typedef struct packed {
        int h_total; int hsync; int burst_start; int burst_len;
        int act_start; int act_len; int v_total; int vsync;
        int v_act_start; int v_act_len;
    } timing_t;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic s, b, a, ls, fs;
    } obs_t;

    localparam timing_t P_A = '{1728, 127, 151, 60, 284, 1404, 312, 3, 23, 288};
    // Small raster: burst ends exactly where active starts, short front porch.
    localparam int B_HT = 40, B_HS = 4, B_BS = 7, B_BL = 3, B_AS = 10, B_AL = 28;
    localparam int B_VT = 12, B_VS = 2, B_VAS = 3, B_VAL = 8;
    localparam timing_t P_B = '{B_HT, B_HS, B_BS, B_BL, B_AS, B_AL, B_VT, B_VS, B_VAS, B_VAL};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce_a = 1'b0, ce_b = 1'b0;
    logic [10:0] h_a;
    logic [8:0]  v_a;
    logic        s_a, b_a, a_a, ls_a, fs_a;
    logic [5:0]  h_b;
    logic [3:0]  v_b;
    logic        s_b, b_b, a_b, ls_b, fs_b;

    int compared = 0;
    int mismatched = 0;
    int n_a = 0, n_b = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce_a),
        .h_cnt(h_a), .v_cnt(v_a), .sync(s_a), .burst(b_a), .active(a_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .H_TOTAL(B_HT), .HSYNC_LEN(B_HS), .BURST_START(B_BS), .BURST_LEN(B_BL),
        .ACTIVE_START(B_AS), .ACTIVE_LEN(B_AL), .V_TOTAL(B_VT), .VSYNC_LINES(B_VS),
        .V_ACT_START(B_VAS), .V_ACT_LEN(B_VAL)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce_b),
        .h_cnt(h_b), .v_cnt(v_b), .sync(s_b), .burst(b_b), .active(a_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // Reference: raster position is just the number of enabled clocks since reset.
    function automatic obs_t calc(input timing_t p, input int n);
        obs_t e;
        int   h, v;
        bit   vs;
        h  = n % p.h_total;
        v  = (n / p.h_total) % p.v_total;
        vs = (v < p.vsync);
        e.h  = 16'(h);
        e.v  = 16'(v);
        e.s  = vs ? (h < p.h_total - p.hsync) : (h < p.hsync);
        e.b  = !vs && h >= p.burst_start && h < p.burst_start + p.burst_len;
        e.a  = h >= p.act_start && h < p.act_start + p.act_len &&
               v >= p.v_act_start && v < p.v_act_start + p.v_act_len;
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic obs_t obs_a();
        return '{16'(h_a), 16'(v_a), s_a, b_a, a_a, ls_a, fs_a};
    endfunction

    function automatic obs_t obs_b();
        return '{16'(h_b), 16'(v_b), s_b, b_b, a_b, ls_b, fs_b};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got h=%0d v=%0d s/b/a/ls/fs=%b%b%b%b%b, expected h=%0d v=%0d s/b/a/ls/fs=%b%b%b%b%b",
                     name, act.h, act.v, act.s, act.b, act.a, act.ls, act.fs,
                     exp.h, exp.v, exp.s, exp.b, exp.a, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_a <= 0;
            n_b <= 0;
        end else begin
            if (ce_a) n_a <= n_a + 1;
            if (ce_b) n_b <= n_b + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle_a", obs_a(), calc(P_A, n_a));
            check("cycle_b", obs_b(), calc(P_B, n_b));
        end
    end

    // Hand-derived {sync,burst,active} for deep positions of the full raster.
    localparam int NPIN = 16;
    int       pin_n   [NPIN] = '{30*1728+126, 30*1728+127, 30*1728+150, 30*1728+151,
                                 30*1728+210, 30*1728+211, 30*1728+283, 30*1728+284,
                                 30*1728+1687, 30*1728+1688, 22*1728+600, 23*1728+600,
                                 310*1728+600, 311*1728+600, 1*1728+1600, 1*1728+1601};
    logic [2:0] pin_sba [NPIN] = '{3'b100, 3'b000, 3'b000, 3'b010,
                                 3'b010, 3'b000, 3'b000, 3'b001,
                                 3'b001, 3'b000, 3'b000, 3'b001,
                                 3'b001, 3'b000, 3'b100, 3'b000};

    // Hand-derived DUT observations during the constant-ce phase: {inst, cycle, h, v, sba}.
    localparam int NLIT = 19;
    bit         lit_b   [NLIT] = '{0, 0, 0, 0, 0,
                                   1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int         lit_i   [NLIT] = '{151, 1727, 1728, 3328, 3329,
                                   35, 36, 48, 95, 135, 203, 204, 207, 209, 210, 237, 238, 415, 455};
    int         lit_h   [NLIT] = '{151, 1727, 0, 1600, 1601,
                                   35, 36, 8, 15, 15, 3, 4, 7, 9, 10, 37, 38, 15, 15};
    int         lit_v   [NLIT] = '{0, 0, 1, 1, 1,
                                   0, 0, 1, 2, 3, 5, 5, 5, 5, 5, 5, 5, 10, 11};
    logic [2:0] lit_sba [NLIT] = '{3'b100, 3'b000, 3'b100, 3'b100, 3'b000,
                                   3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b100, 3'b000,
                                   3'b010, 3'b010, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000};

    initial begin
        obs_t e;
        obs_t o;
        int   ls_count, fs_count, guard;

        for (int k = 0; k < NPIN; k++) begin
            e = calc(P_A, pin_n[k]);
            check_int($sformatf("model_pin_%0d", k), int'({e.s, e.b, e.a}), int'(pin_sba[k]));
        end
        e = calc(P_A, 312*1728);
        check_int("model_frame_wrap", int'({e.h, e.v, e.fs}), 1);

        #2 rst_n = 1'b0;
        #20 started = 1'b1;

        // Constant ce from reset release.
        @(negedge clk);
        rst_n = 1'b1;
        ce_a = 1'b1;
        ce_b = 1'b1;
        ls_count = 0;
        fs_count = 0;
        for (int i = 0; i < 3456; i++) begin
            if (ls_a) ls_count++;
            if (fs_b) fs_count++;
            for (int k = 0; k < NLIT; k++) begin
                if (lit_i[k] == i) begin
                    o = lit_b[k] ? obs_b() : obs_a();
                    check_int($sformatf("lit_%0d", k),
                              int'({o.h, o.v, o.s, o.b, o.a}),
                              int'({16'(lit_h[k]), 16'(lit_v[k]), lit_sba[k]}));
                end
            end
            @(negedge clk);
        end
        check_int("line_start_count_a", ls_count, 2);
        check_int("frame_start_count_b", fs_count, 8);

        // Stall at the last pixel of the frame: 1,0,0,1 then hold the wrap.
        ce_a = 1'b0;
        guard = 0;
        while (n_b % 480 != 478 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_int("steer_b_timeout", int'(guard < 1000), 1);
        @(negedge clk);
        ce_b = 1'b0;
        check("stall_pre", obs_b(), '{16'd39, 16'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) begin
            @(negedge clk);
            check("stall_hold", obs_b(), '{16'd39, 16'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        ce_b = 1'b1;
        @(negedge clk);
        ce_b = 1'b0;
        check("stall_wrap", obs_b(), '{16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        repeat (2) begin
            @(negedge clk);
            check("stall_fs_held", obs_b(), '{16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        ce_b = 1'b1;
        @(negedge clk);
        check("stall_resume", obs_b(), '{16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Park both rasters mid-line, then reset asynchronously between edges.
        ce_b = 1'b0;
        ce_a = 1'b1;
        guard = 0;
        while (n_a % 1728 != 500 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        ce_a = 1'b0;
        check_int("steer_a_timeout", int'(guard < 2000), 1);
        ce_b = 1'b1;
        guard = 0;
        while (n_b % 480 != 225 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        ce_b = 1'b0;
        check_int("steer_b2_timeout", int'(guard < 1000), 1);
        @(negedge clk);
        check_int("pre_reset_h_a", int'(h_a), 500);
        check("pre_reset_b", obs_b(), '{16'd25, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        ce_a = 1'b1;
        ce_b = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_a", obs_a(), '{16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        check("async_reset_b", obs_b(), '{16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("resume_a", obs_a(), '{16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("resume_b", obs_b(), '{16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Random clock-enable patterns; the per-cycle comparison does the checking.
        for (int i = 0; i < 20000; i++) begin
            ce_a = ($urandom_range(0, 3) != 0);
            ce_b = ($urandom_range(0, 1) != 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
